sigmoid_pipe: RTL and testbench
===============================

// Module: sigmoid_pipe
// PURPOSE
//  Streaming, pipelined successor to the combinational piecewise-linear sigmoid.
//  Parametrised Q-format; per-sample mode select (sigmoid or tanh, tanh = 2*sig(2x)-1).
//  valid/ready handshake on both sides, with bubble-collapsing stall logic.
//  Sits between the VAE encoder MAC array and the latent/decoder activation stage.
// PARAMETERS
//  BITS   16  total data width, two's complement, Q(BITS-FRAC).FRAC
//  FRAC   8   fractional bits; FRAC>=5 and BITS-FRAC>=4 are required (elaboration error otherwise)
//  TAG_W  4   width of the sideband tag carried alongside each sample
// PORTS
//  clock      in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      input sample valid
//  in_ready   out  1      block accepts the sample this cycle
//  in_data    in   BITS   x, signed
//  in_mode    in   1      0 = sigmoid, 1 = tanh; sampled with in_data
//  in_tag     in   TAG_W  sideband, passed through unchanged
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts the result
//  out_data   out  BITS   y, signed, same Q-format as the input
//  out_sat    out  1      |x'| >= 5.0 (flat region); x' = x for sigmoid, 2x for tanh
//  out_tag    out  TAG_W  in_tag of the same sample
// BEHAVIOUR
//  - One clock domain, single rst. All regs reset when rst=1 at the clock edge.
//  - Reset values: out_valid=0, out_data=0, out_sat=0, out_tag=0. All stage valids are 0.
//  - Reset mid-operation discards every in-flight sample. No output is produced for discarded samples.
//  - Pipeline has 3 register stages S1..S3; S3 drives the out_* ports. Latency is 3 cycles with no stall.
//  - Per stage: v_k is the valid bit; rdy_k = !v_k || rdy_{k+1}; rdy_4 = out_ready.
//  - in_ready = rdy_1 (combinational through the chain). Input transfers when in_valid && in_ready.
//  - Stage k loads from stage k-1 when rdy_k. Otherwise it holds its value. Bubbles collapse.
//  - Output transfers when out_valid && out_ready. Under stall, out_* stays stable until the transfer.
//  - Throughput is 1 sample/cycle while out_ready=1.
//  - S1:
//    - x' = x (mode 0) or sat(2x) (mode 1). sat clamps to [-2^(BITS-1), 2^(BITS-1)-1].
//    - a = |x'|; |min_neg| saturates to max_pos.
//    - Select the segment, using ONE = 1<<FRAC:
//      seg0 a<ONE; seg1 a<2.375*ONE; seg2 a<5*ONE; seg3 otherwise.
//  - S2, positive-half value p (shifts truncate toward zero):
//    - seg0: (a>>2) + ONE/2
//    - seg1: (a>>3) + 5<<(FRAC-3)
//    - seg2: (a>>5) + 27<<(FRAC-5)
//    - seg3: ONE
//  - S3:
//    - s = (x'<0) ? ONE-p : p.
//    - y = s (mode 0) or 2s-ONE (mode 1).
//    - Result ranges: sigmoid [0,ONE], tanh [-ONE,ONE]; no overflow is possible.
//    - out_sat = (seg==3).
//    - mode, tag and sign travel with the sample through every stage.
//  - Boundaries:
//    - x exactly on a breakpoint takes the upper segment (1.0 -> seg1, 5.0 -> seg3).
//    - x = 0 -> sigmoid 0.5, tanh 0.
// TESTING
//  - Sigmoid, defaults: x=0x0000 -> 0x0080; 0x0100 -> 0x00C0; 0xFF00 -> 0x0040.
//    Also 0x0280 -> 0x00EC; 0x0500 -> 0x0100 with sat=1; 0xFB00 -> 0x0000 with sat=1.
//  - Extremes: 0x7FFF -> 0x0100; 0x8000 -> 0x0000. Both give sat=1.
//  - Tanh: x=0x0000 -> 0x0000; 0x0100 -> 0x00C0; 0xFF00 -> 0xFF40; 0x0300 -> 0x0100 with sat=1.
//  - Sweep x=0xF900..0x0700 back-to-back, mode alternating each sample, out_ready=1:
//    - the output stream matches the golden model one-for-one;
//    - out_valid is first seen 3 cycles after the first accept;
//    - out_tag echoes a count pattern.
//  - Backpressure: random out_ready and in_valid, 10k samples:
//    - no sample is lost or duplicated and order is preserved;
//    - out_* is stable while out_valid && !out_ready;
//    - in_ready=0 only when all 3 stages are full and out_ready=0.
//  - Reset with 3 samples in flight and out_ready=0:
//    - the next cycle has out_valid=0, out_data=0 and in_ready=1;
//    - none of the flushed samples ever appears.

Source files
------------

// File: rtl/sigmoid_if.sv
// Streaming handshake bundle for sigmoid_pipe.
// Input side:  in_valid / in_ready / in_data / in_mode / in_tag
// Output side: out_valid / out_ready / out_data / out_sat / out_tag
// slave  : seen from the pipeline (consumes in_*, produces out_*)
// master : seen from the surrounding logic (produces in_*, consumes out_*)
interface sigmoid_if #(
  parameter int BITS  = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [BITS-1:0]  in_data;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [BITS-1:0]  out_data;
  logic             out_sat;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_data, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_tag
  );

  modport master (
    output in_valid, in_data, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_tag
  );
endinterface

// File: rtl/sigmoid_pipe.sv
// Three-stage streaming piecewise-linear sigmoid / tanh.
//   clock : rising-edge clock
//   rst   : synchronous reset, active-high
//   bus   : sigmoid_if.slave handshake bundle
//           in_*  : signed Q(BITS-FRAC).FRAC sample, mode (0 sigmoid, 1 tanh), tag
//           out_* : signed result in the same Q-format, flat-region flag, tag
// S1 forms x' and its magnitude and picks the segment, S2 evaluates the
// positive-half line, S3 mirrors for negative inputs and applies the tanh map.
module sigmoid_pipe #(
  parameter int BITS  = 16,
  parameter int FRAC  = 8,
  parameter int TAG_W = 4
) (
  input  logic     clock,
  input  logic     rst,
  sigmoid_if.slave bus
);

  if (FRAC < 5 || BITS - FRAC < 4) begin : g_bad_params
    $error("sigmoid_pipe: FRAC must be >= 5 and BITS-FRAC must be >= 4");
  end

  typedef enum logic [1:0] {SEG0, SEG1, SEG2, SEG3} seg_e;

  localparam logic [BITS-1:0] ONE    = BITS'(1)  << FRAC;
  localparam logic [BITS-1:0] HALF   = BITS'(1)  << (FRAC - 1);
  localparam logic [BITS-1:0] BRK1   = BITS'(19) << (FRAC - 3);  // 2.375
  localparam logic [BITS-1:0] BRK2   = BITS'(5)  << FRAC;        // 5.0
  localparam logic [BITS-1:0] OFS1   = BITS'(5)  << (FRAC - 3);  // 0.625
  localparam logic [BITS-1:0] OFS2   = BITS'(27) << (FRAC - 5);  // 0.84375
  localparam logic [BITS-1:0] MAX_POS = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] MIN_NEG = {1'b1, {(BITS-1){1'b0}}};
  localparam logic signed [BITS:0] SAT_HI = {2'b00, {(BITS-1){1'b1}}};
  localparam logic signed [BITS:0] SAT_LO = {2'b11, {(BITS-1){1'b0}}};

  typedef struct packed {
    logic             mode;
    logic [TAG_W-1:0] tag;
    logic             neg;
    seg_e             seg;
    logic [BITS-1:0]  mag;   // |x'| in S1, positive-half value p in S2
  } stage_t;

  // Handshake chain: a stage can take new data if it is empty or its
  // successor is taking its current content this cycle.
  logic v1, v2, v3;
  logic rdy1, rdy2, rdy3;

  // NOTE: ready runs combinationally from out_ready back to in_ready so a
  // single free slot anywhere lets the upstream bubbles collapse in one cycle.
  assign rdy3          = !v3 || bus.out_ready;
  assign rdy2          = !v2 || rdy3;
  assign rdy1          = !v1 || rdy2;
  assign bus.in_ready  = rdy1;
  assign bus.out_valid = v3;

  // ---------------- S1: x', magnitude, segment ----------------
  logic signed [BITS:0] x_ext, x_dbl;
  logic [BITS-1:0]      x_prime;
  stage_t               s1_nxt, s1;

  // NOTE: every variable gets its default at the top of the block, so no
  // path through the ifs can leave it unassigned and infer a latch.
  always_comb begin
    x_ext   = {bus.in_data[BITS-1], bus.in_data};
    x_dbl   = x_ext <<< 1;   // 2x of a BITS-bit value always fits in BITS+1
    x_prime = bus.in_data;
    if (bus.in_mode) begin
      if (x_dbl > SAT_HI)      x_prime = MAX_POS;
      else if (x_dbl < SAT_LO) x_prime = MIN_NEG;
      else                     x_prime = x_dbl[BITS-1:0];
    end

    s1_nxt      = '0;
    s1_nxt.mode = bus.in_mode;
    s1_nxt.tag  = bus.in_tag;
    s1_nxt.neg  = x_prime[BITS-1];
    if (x_prime == MIN_NEG)  s1_nxt.mag = MAX_POS;
    else if (s1_nxt.neg)     s1_nxt.mag = -x_prime;
    else                     s1_nxt.mag = x_prime;

    // Breakpoints belong to the upper segment.
    if (s1_nxt.mag < ONE)       s1_nxt.seg = SEG0;
    else if (s1_nxt.mag < BRK1) s1_nxt.seg = SEG1;
    else if (s1_nxt.mag < BRK2) s1_nxt.seg = SEG2;
    else                        s1_nxt.seg = SEG3;
  end

  // ---------------- S2: positive-half line ----------------
  stage_t s2_nxt, s2;

  always_comb begin
    s2_nxt = s1;
    unique case (s1.seg)
      SEG0:    s2_nxt.mag = (s1.mag >> 2) + HALF;
      SEG1:    s2_nxt.mag = (s1.mag >> 3) + OFS1;
      SEG2:    s2_nxt.mag = (s1.mag >> 5) + OFS2;
      default: s2_nxt.mag = ONE;
    endcase
  end

  // ---------------- S3: mirror and tanh map ----------------
  // p <= ONE and 2*ONE fits below the sign bit, so the unsigned arithmetic
  // below wraps into the correct two's-complement result.
  logic [BITS-1:0] s_val, y_nxt;

  always_comb begin
    s_val = s2.neg ? (ONE - s2.mag) : s2.mag;
    y_nxt = s2.mode ? ((s_val << 1) - ONE) : s_val;
  end

  // NOTE: all state, payload included, is cleared by reset so the outputs
  // read as zero afterwards and flushed samples cannot leak out.
  // NOTE: registered state uses non-blocking assignments only, so every
  // stage samples its predecessor's pre-edge value.
  always_ff @(posedge clock) begin
    if (rst) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      v3           <= 1'b0;
      s1           <= '0;
      s2           <= '0;
      bus.out_data <= '0;
      bus.out_sat  <= 1'b0;
      bus.out_tag  <= '0;
    end else begin
      if (rdy1) begin
        v1 <= bus.in_valid;
        s1 <= s1_nxt;
      end
      if (rdy2) begin
        v2 <= v1;
        s2 <= s2_nxt;
      end
      if (rdy3) begin
        v3           <= v2;
        bus.out_data <= y_nxt;
        bus.out_sat  <= (s2.seg == SEG3);
        bus.out_tag  <= s2.tag;
      end
    end
  end

endmodule

// File: tb/tb_sigmoid_pipe.sv
// Self-checking bench for sigmoid_pipe: directed literal vectors, a full
// sweep with alternating modes, random backpressure and a mid-flight reset.
// Expected results come from an integer model of the piecewise-linear curve.
`timescale 1ns/1ps
module tb_sigmoid_pipe;
  localparam int BITS  = 16;
  localparam int FRAC  = 8;
  localparam int TAG_W = 4;
  localparam int ONE_I = 1 << FRAC;

  typedef struct packed {
    logic [BITS-1:0]  y;
    logic             sat;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct packed {
    logic [BITS-1:0] x;
    logic            mode;
    logic [BITS-1:0] y;
    logic            sat;
  } dir_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sigmoid_if #(.BITS(BITS), .TAG_W(TAG_W)) bus ();

  sigmoid_pipe #(.BITS(BITS), .FRAC(FRAC), .TAG_W(TAG_W)) dut (
    .clock (clk),
    .rst   (rst),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  int   occ = 0;
  bit   stalled = 1'b0;
  exp_t prev_out;
  bit   measuring = 1'b0;
  bit   rand_rdy  = 1'b0;
  int   first_acc = -1;
  int   first_out = -1;

  dir_t dirs[16] = '{
    '{16'h0000, 1'b0, 16'h0080, 1'b0},
    '{16'h0100, 1'b0, 16'h00C0, 1'b0},
    '{16'hFF00, 1'b0, 16'h0040, 1'b0},
    '{16'h0280, 1'b0, 16'h00EC, 1'b0},
    '{16'h0500, 1'b0, 16'h0100, 1'b1},
    '{16'hFB00, 1'b0, 16'h0000, 1'b1},
    '{16'h7FFF, 1'b0, 16'h0100, 1'b1},
    '{16'h8000, 1'b0, 16'h0000, 1'b1},
    '{16'h04FF, 1'b0, 16'h00FF, 1'b0},
    '{16'h0260, 1'b0, 16'h00EB, 1'b0},
    '{16'hFFFF, 1'b0, 16'h0080, 1'b0},
    '{16'h0000, 1'b1, 16'h0000, 1'b0},
    '{16'h0100, 1'b1, 16'h00C0, 1'b0},
    '{16'hFF00, 1'b1, 16'hFF40, 1'b0},
    '{16'h0300, 1'b1, 16'h0100, 1'b1},
    '{16'h8000, 1'b1, 16'hFF00, 1'b1}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the curve in plain integer arithmetic; returns {sat, y}.
  function automatic logic [BITS:0] golden(input logic [BITS-1:0] x, input logic mode);
    int xi, xp, a, p, s, y;
    xi = int'($signed(x));
    xp = mode ? 2 * xi : xi;
    if (xp > 32767)  xp = 32767;
    if (xp < -32768) xp = -32768;
    a = (xp < 0) ? -xp : xp;
    if (a > 32767) a = 32767;
    if (a < ONE_I)               p = a / 4 + ONE_I / 2;
    else if (8 * a < 19 * ONE_I) p = a / 8 + (5 * ONE_I) / 8;
    else if (a < 5 * ONE_I)      p = a / 32 + (27 * ONE_I) / 32;
    else                         p = ONE_I;
    s = (xp < 0) ? ONE_I - p : p;
    y = mode ? 2 * s - ONE_I : s;
    return {a >= 5 * ONE_I, BITS'(y)};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 99) < 60);
  end

  // Scoreboard / protocol monitor, sampled on the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      occ     = 0;
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("stable_under_stall", {bus.out_valid, bus.out_data, bus.out_sat, bus.out_tag},
              {1'b1, prev_out});
      check("in_ready", bus.in_ready, !(occ == 3 && !bus.out_ready));
      if (measuring && bus.out_valid && first_out < 0) first_out = cyc;
      if (bus.out_valid && bus.out_ready) begin
        check("output_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e.y);
          check("out_sat",  bus.out_sat,  e.sat);
          check("out_tag",  bus.out_tag,  e.tag);
          occ--;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.tag = bus.in_tag;
        {e.sat, e.y} = golden(bus.in_data, bus.in_mode);
        exp_q.push_back(e);
        occ++;
        if (measuring && first_acc < 0) first_acc = cyc;
      end
      stalled  = bus.out_valid && !bus.out_ready;
      prev_out = '{bus.out_data, bus.out_sat, bus.out_tag};
    end
  end

  task automatic send(input logic [BITS-1:0] x, input logic mode, input logic [TAG_W-1:0] tag);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    bus.in_mode  = mode;
    bus.in_tag   = tag;
    @(negedge clk);
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("send_ready_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    #2;
  endtask

  task automatic run_one(input dir_t d, input logic [TAG_W-1:0] tag);
    int n = 0;
    send(d.x, d.mode, tag);
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("dir_valid", bus.out_valid, 1);
    check("dir_data",  bus.out_data,  d.y);
    check("dir_sat",   bus.out_sat,   d.sat);
    check("dir_tag",   bus.out_tag,   tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_out_sat",   bus.out_sat,   0);
    check("rst_out_tag",   bus.out_tag,   0);
    check("rst_in_ready",  bus.in_ready,  1);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Pin the model, then run the same vectors through the DUT
    foreach (dirs[i]) check("model_pin", golden(dirs[i].x, dirs[i].mode), {dirs[i].sat, dirs[i].y});
    foreach (dirs[i]) run_one(dirs[i], TAG_W'(i));
    drain();

    // Sweep, back-to-back, alternating mode, counting tag
    first_acc = -1;
    first_out = -1;
    measuring = 1'b1;
    for (int i = 0; i < 16'h0700 + 16'h0700 + 1; i++)
      send(BITS'(16'hF900 + i), i[0], TAG_W'(i));
    drain();
    measuring = 1'b0;
    check("sweep_latency", first_out - first_acc, 3);

    // Random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        @(posedge clk);
        #1;
      end
      send(BITS'($urandom), 1'($urandom_range(0, 1)), TAG_W'(i));
    end
    drain();

    // Reset with three samples in flight and the output stalled
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(16'h0100, 1'b0, 4'h1);
    send(16'h0200, 1'b1, 4'h2);
    send(16'hFF00, 1'b0, 4'h3);
    check("full_in_ready", bus.in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_out_data",  bus.out_data,  0);
    check("flush_in_ready",  bus.in_ready,  1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("flush_no_output", bus.out_valid, 0);
    end
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
